// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU opcodes, loader state encoding and opcode legality check.
package alu_pkg;
    localparam int DATA_W = 8;
    localparam int OP_W   = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } ld_state_e;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    endfunction
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: 2-flop synchronizer and rising-edge pulse for the "next" button;
// ALU_LOADER_DEBOUNCE_EN inserts a stable-level debounce counter before the edge detector.
module btn_edge_sync
`ifdef ALU_LOADER_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic next_p_o
);
    logic sync1_q, sync2_q, prev_q, lvl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= lvl;
        end
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;

    // Any cycle where the synchronized input agrees with the debounced level restarts the count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync2_q != db_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(DEBOUNCE_CYCLES)) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign lvl = db_q;
`else
    assign lvl = sync2_q;
`endif

    assign next_p_o = lvl & ~prev_q;
endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: steps A, B and opcode from the switches into the ALU on each button press,
// then captures the result after a settle time. Optional debounce via ALU_LOADER_DEBOUNCE_EN.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
`ifdef ALU_LOADER_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 16
`endif
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_next,
    input  logic [DATA_W-1:0] alu_rdo,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] result,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              result_valid,
    output logic              op_err,
    output logic [2:0]        state_o
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    ld_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              carry_q, carry_d, zero_q, zero_d, valid_q, valid_d, err_q, err_d;
    logic              next_p;

    btn_edge_sync
`ifdef ALU_LOADER_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_btn (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (btn_next),
        .next_p_o (next_p)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            LOAD_A: if (next_p) begin
                a_d     = sw;
                state_d = LOAD_B;
            end
            LOAD_B: if (next_p) begin
                b_d     = sw;
                state_d = LOAD_OP;
            end
            LOAD_OP: if (next_p) begin
                if (is_legal_op(sw[OP_W-1:0])) begin
                    op_d    = sw[OP_W-1:0];
                    cnt_d   = '0;
                    state_d = EXEC;
                end else begin
                    err_d = 1'b1;
                end
            end
            // Button presses are ignored while the ALU inputs settle.
            EXEC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    res_d   = alu_rdo;
                    carry_d = alu_carry;
                    zero_d  = alu_zero;
                    valid_d = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: if (next_p) begin
                valid_d = 1'b0;
                state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign result       = res_q;
    assign carry_flag   = carry_q;
    assign zero_flag    = zero_q;
    assign result_valid = valid_q;
    assign op_err       = err_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: table-driven operand/opcode loads against a small ALU model,
// plus hand-written illegal-opcode and reset-during-EXEC sequences.
module tb_alu_operand_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw = 8'h00;
    logic       btn_next = 1'b0;
    logic [7:0] alu_rdo;
    logic       alu_carry, alu_zero;
    logic [7:0] alu_a, alu_b, result;
    logic [5:0] alu_op;
    logic       carry_flag, zero_flag, result_valid, op_err;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    alu_operand_loader dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .btn_next     (btn_next),
        .alu_rdo      (alu_rdo),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .result       (result),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
        .result_valid (result_valid),
        .op_err       (op_err),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Combinational ALU standing in for the real one; SUB carry is the borrow.
    always_comb begin
        {alu_carry, alu_rdo} = 9'h000;
        case (alu_op)
            6'h20: {alu_carry, alu_rdo} = {1'b0, alu_a} + {1'b0, alu_b};
            6'h22: {alu_carry, alu_rdo} = {1'b0, alu_a} - {1'b0, alu_b};
            6'h24: alu_rdo = alu_a & alu_b;
            6'h25: alu_rdo = alu_a | alu_b;
            6'h26: alu_rdo = alu_a ^ alu_b;
            6'h27: alu_rdo = ~(alu_a | alu_b);
            6'h03: alu_rdo = {alu_a[7], alu_a[7:1]};
            6'h02: alu_rdo = {1'b0, alu_a[7:1]};
            default: alu_rdo = 8'h00;
        endcase
        alu_zero = (alu_rdo == 8'h00);
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        logic       c;
        logic       z;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Held for 5 cycles so exactly one synchronized rising edge is seen.
    task automatic press(input logic [7:0] v);
        sw = v;
        btn_next = 1'b1;
        tick(5);
        btn_next = 1'b0;
        tick(4);
    endtask

    initial begin
        int err_cycles;
        int bound;
        vecs[0] = '{8'h0F, 8'h01, 6'h20, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 6'h20, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'h80, 8'h55, 6'h03, 8'hC0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h55, 6'h02, 8'h40, 1'b0, 1'b0};
        vecs[4] = '{8'hF0, 8'h0F, 6'h24, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{8'hF0, 8'h0F, 6'h25, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'hFF, 6'h26, 8'h55, 1'b0, 1'b0};
        vecs[7] = '{8'h05, 8'h03, 6'h22, 8'h02, 1'b0, 1'b0};
        vecs[8] = '{8'h03, 8'h05, 6'h22, 8'hFE, 1'b1, 1'b0};
        vecs[9] = '{8'h0F, 8'hF0, 6'h27, 8'h00, 1'b0, 1'b1};

        tick(2);
        chk("rst_state", state_o, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_op", alu_op, 6'h20);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry_flag, zero_flag, result_valid, op_err}, 0);
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < 10; i++) begin
            press(vecs[i].a);
            chk($sformatf("v%0d_stateB", i), state_o, 1);
            chk($sformatf("v%0d_a", i), alu_a, vecs[i].a);
            press(vecs[i].b);
            chk($sformatf("v%0d_b", i), alu_b, vecs[i].b);
            press({2'b00, vecs[i].op});
            chk($sformatf("v%0d_state", i), state_o, 4);
            chk($sformatf("v%0d_op", i), alu_op, vecs[i].op);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_carry", i), carry_flag, vecs[i].c);
            chk($sformatf("v%0d_zero", i), zero_flag, vecs[i].z);
            chk($sformatf("v%0d_valid", i), result_valid, 1);
            press(8'h00);
            chk($sformatf("v%0d_back_state", i), state_o, 0);
            chk($sformatf("v%0d_back_valid", i), result_valid, 0);
        end

        // Illegal opcode: one op_err cycle, stay in LOAD_OP, alu_op unchanged.
        press(8'h09);
        press(8'h04);
        chk("ill_pre_state", state_o, 2);
        sw = 8'h3F;
        btn_next = 1'b1;
        err_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (op_err) err_cycles++;
        end
        btn_next = 1'b0;
        tick(4);
        chk("ill_err_cycles", err_cycles, 1);
        chk("ill_state", state_o, 2);
        chk("ill_op_kept", alu_op, 6'h27);
        press(8'h22);
        chk("sub_state", state_o, 4);
        chk("sub_op", alu_op, 6'h22);
        chk("sub_result", result, 8'h05);
        chk("sub_valid", result_valid, 1);
        press(8'h00);
        chk("sub_back_state", state_o, 0);

        // Reset in the first EXEC cycle: no capture before or after.
        press(8'h10);
        press(8'h20);
        sw = 8'h20;
        btn_next = 1'b1;
        bound = 0;
        while (state_o != 3 && bound < 10) begin
            tick(1);
            bound++;
        end
        chk("exec_reached", state_o, 3);
        reset = 1'b1;
        btn_next = 1'b0;
        #1;
        chk("mid_rst_state", state_o, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_a", alu_a, 0);
        chk("mid_rst_op", alu_op, 6'h20);
        tick(2);
        reset = 1'b0;
        tick(6);
        chk("post_rst_state", state_o, 0);
        chk("post_rst_result", result, 0);
        chk("post_rst_valid", result_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
